// File: rtl/wait_state_mem.sv
// Word-organised memory with req/ready handshake and LATENCY wait states.
// Optional WAIT_STATE_MEM_READBACK_EN: write commits return the merged word on rd.
module wait_state_mem #(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 64,
  parameter int    ADDR_W    = 32,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = "riscvtest.txt"
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   a,
  input  logic [DATA_W-1:0]   wd,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic [DATA_W-1:0]   rd,
  output logic                busy,
  output logic                err
);

  localparam int NB  = DATA_W / 8;
  localparam int OFF = (NB > 1) ? $clog2(NB) : 0;
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // state | meaning
  // IDLE  | ready for a request, busy=0
  // WAIT  | access latched, counting down wait states
  // RESP  | ready pulse, rd/err valid
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] a_q;
  logic              we_q;
  logic [DATA_W-1:0] wd_q;
  logic [NB-1:0]     be_q;

  logic [DATA_W-1:0] mem [DEPTH];

  // In IDLE the live inputs feed the commit so LATENCY=1 can commit on the accept edge.
  logic [ADDR_W-1:0] cmd_a;
  logic              cmd_we;
  logic [DATA_W-1:0] cmd_wd;
  logic [NB-1:0]     cmd_be;
  logic [ADDR_W-1:0] idx;
  logic [IW-1:0]     word_idx;
  logic              oor;
  logic              commit;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged;

  assign cmd_a    = (state == IDLE) ? a  : a_q;
  assign cmd_we   = (state == IDLE) ? we : we_q;
  assign cmd_wd   = (state == IDLE) ? wd : wd_q;
  assign cmd_be   = (state == IDLE) ? be : be_q;
  assign idx      = cmd_a >> OFF;
  assign word_idx = idx[IW-1:0];
  assign oor      = (idx >= ADDR_W'(DEPTH));
  assign commit   = ((state == IDLE) && req && (LATENCY == 1)) ||
                    ((state == WAIT) && (cnt == 4'd1));
  assign old_word = mem[word_idx];

  always_comb begin
    merged = old_word;
    for (int i = 0; i < NB; i++) begin
      if (cmd_be[i]) merged[8*i +: 8] = cmd_wd[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && commit && cmd_we && !oor) mem[word_idx] <= merged;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ready <= 1'b0;
      busy  <= 1'b0;
      rd    <= '0;
      err   <= 1'b0;
      a_q   <= '0;
      we_q  <= 1'b0;
      wd_q  <= '0;
      be_q  <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            a_q  <= a;
            we_q <= we;
            wd_q <= wd;
            be_q <= be;
            busy <= 1'b1;
            if (LATENCY == 1) begin
              state <= RESP;
              ready <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
            ready <= 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (commit) begin
        if (oor) begin
          rd  <= '0;
          err <= 1'b1;
        end else begin
          err <= 1'b0;
          if (!cmd_we) begin
            rd <= old_word;
          end else begin
`ifdef WAIT_STATE_MEM_READBACK_EN
            rd <= merged;
`else
            rd <= rd;
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wait_state_mem.sv
// Directed bench for wait_state_mem at LATENCY=3, DEPTH=64, 32-bit words.
module tb_wait_state_mem;

`ifdef WAIT_STATE_MEM_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, req, we;
  logic [31:0] a, wd;
  logic [3:0]  be;
  logic        ready, busy, err;
  logic [31:0] rd;

  int checks = 0;
  int errors = 0;

  wait_state_mem #(
    .DATA_W(32), .DEPTH(64), .ADDR_W(32), .LATENCY(3), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .a(a), .wd(wd), .be(be),
    .ready(ready), .rd(rd), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access: req for one cycle, inputs scrambled while busy, ready expected on the 3rd sample.
  task automatic access(input string tag, input logic w, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] bytes,
                        input logic [31:0] exp_rd, input logic exp_err);
    int n;
    @(negedge clk);
    req = 1'b1; we = w; a = addr; wd = data; be = bytes;
    @(negedge clk);
    req = 1'b0; we = ~w; a = 32'h0000_0004; wd = ~data; be = ~bytes;
    n = 1;
    while (!ready && n < 10) begin
      chk({tag, "_busy_wait"}, 32'(busy), 32'd1);
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd3);
    chk({tag, "_busy_resp"}, 32'(busy), 32'd1);
    chk({tag, "_rd"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    @(negedge clk);
    chk({tag, "_ready_drop"}, 32'(ready), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [11:0] rdy_v, busy_v;
    int pulses;
    reset = 1'b1; req = 1'b0; we = 1'b0; a = '0; wd = '0; be = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd", rd, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;

    access("w0", 1'b1, 32'h0, 32'h0050_0113, 4'hF, RB ? 32'h0050_0113 : 32'h0, 1'b0);
    access("r0", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0050_0113, 1'b0);

    access("w10_full", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, RB ? 32'hDEAD_BEEF : 32'h0050_0113, 1'b0);
    access("r10_full", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    access("w10_lane0", 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, RB ? 32'hDEAD_BEAA : 32'hDEAD_BEEF, 1'b0);
    access("r10_lane0", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0);
    access("w10_be0", 1'b1, 32'h10, 32'h1111_1111, 4'b0000, 32'hDEAD_BEAA, 1'b0);
    access("r10_be0", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0);

    access("wfc_last", 1'b1, 32'hFC, 32'hCAFE_F00D, 4'hF, RB ? 32'hCAFE_F00D : 32'hDEAD_BEAA, 1'b0);
    access("rfc_last", 1'b0, 32'hFC, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
    access("r100_oor", 1'b0, 32'h100, 32'h0, 4'h0, 32'h0, 1'b1);
    access("w100_oor", 1'b1, 32'h100, 32'h5555_5555, 4'hF, 32'h0, 1'b1);
    access("r0_after_oor", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0050_0113, 1'b0);
    access("r_alias0", 1'b0, 32'h3, 32'h0, 4'h0, 32'h0050_0113, 1'b0);

    // req held high: accept every 4 cycles, ready on samples 2, 6, 10
    req = 1'b1; we = 1'b0; a = 32'h0; wd = '0; be = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      rdy_v[k]  = ready;
      busy_v[k] = busy;
    end
    req = 1'b0;
    chk("held_ready_pattern", 32'(rdy_v), 32'h444);
    chk("held_busy_pattern", 32'(busy_v), 32'h777);
    chk("held_rd", rd, 32'h0050_0113);

    access("w20_seed", 1'b1, 32'h20, 32'h1122_3344, 4'hF, RB ? 32'h1122_3344 : 32'h0050_0113, 1'b0);
    access("r20_seed", 1'b0, 32'h20, 32'h0, 4'h0, 32'h1122_3344, 1'b0);

    // reset one cycle after accept
    @(negedge clk);
    req = 1'b1; we = 1'b1; a = 32'h20; wd = 32'h1234_5678; be = 4'hF;
    @(negedge clk);
    req = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_rd", rd, 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      pulses += int'(ready);
    end
    chk("midrst_no_pulse", 32'(pulses), 32'd0);
    access("r20_midrst", 1'b0, 32'h20, 32'h0, 4'h0, 32'h1122_3344, 1'b0);

    // reset coinciding with the commit edge
    @(negedge clk);
    req = 1'b1; we = 1'b1; a = 32'h20; wd = 32'hBAD0_BAD0; be = 4'hF;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("commitrst_busy", 32'(busy), 32'd0);
    chk("commitrst_ready", 32'(ready), 32'd0);
    access("r20_commitrst", 1'b0, 32'h20, 32'h0, 4'h0, 32'h1122_3344, 1'b0);

    access("w20_upper", 1'b1, 32'h20, 32'hFFFF_0000, 4'b1100, RB ? 32'hFFFF_3344 : 32'h1122_3344, 1'b0);
    access("r20_upper", 1'b0, 32'h20, 32'h0, 4'h0, 32'hFFFF_3344, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
